csr_exec_unit: RTL and testbench

//  Executes Zicsr instructions (CSRRW/S/C and immediate forms) as a sequenced read-modify-write

---
 rtl/csr_exec_unit.sv | 153 +++++++++++++++
 tb/tb_csr_exec_unit.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/csr_exec_unit.sv
// Zicsr read-modify-write sequencer in front of the machine CSR file: accept -> READ -> (WRITE) -> RESP.
// Response is ready 2 cycles after accept without a write and 3 with one; a stalled response blocks new requests.
module csr_exec_unit #(
  parameter int XLEN          = 64,
  parameter int CAUSE_ILLEGAL = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_funct3,
  input  logic [11:0]     req_csr,
  input  logic [4:0]      req_rs1_idx,
  input  logic [XLEN-1:0] req_rs1_val,
  input  logic [4:0]      req_rd_idx,
  input  logic [XLEN-1:0] req_pc,
  output logic [11:0]     csr_addr,
  output logic            csr_we,
  output logic [XLEN-1:0] csr_wdata,
  input  logic [XLEN-1:0] csr_rdata,
  input  logic            csr_illegal,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic            rsp_rd_we,
  output logic [4:0]      rsp_rd_idx,
  output logic [XLEN-1:0] rsp_rd_data,
  output logic            rsp_trap,
  output logic [XLEN-1:0] rsp_cause,
  output logic [XLEN-1:0] rsp_tval,
  output logic [XLEN-1:0] rsp_pc
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t          r_state;
  logic [2:0]      r_funct3;
  logic [11:0]     r_csr;
  logic [4:0]      r_rs1_idx;
  logic [XLEN-1:0] r_rs1_val;
  logic [4:0]      r_rd_idx;
  logic [XLEN-1:0] r_pc;
  logic            r_csr_we;
  logic [XLEN-1:0] r_csr_wdata;
  logic            r_rsp_valid;
  logic            r_rsp_rd_we;
  logic [XLEN-1:0] r_rsp_rd_data;
  logic            r_rsp_trap;
  logic [XLEN-1:0] r_rsp_cause;
  logic [XLEN-1:0] r_rsp_tval;

  logic [XLEN-1:0] w_op;
  logic [XLEN-1:0] w_new;
  logic            w_do_write;
  logic            w_trap;

  // Immediate forms use the rs1 field itself as an unsigned 5-bit operand.
  always_comb begin
    w_op  = r_funct3[2] ? {{(XLEN-5){1'b0}}, r_rs1_idx} : r_rs1_val;
    w_new = '0;
    case (r_funct3[1:0])
      2'b01:   w_new = w_op;
      2'b10:   w_new = csr_rdata | w_op;
      2'b11:   w_new = csr_rdata & ~w_op;
      default: w_new = '0;
    endcase
  end

  // Set/clear with rs1 index 0 is a pure read, so it may touch read-only CSRs.
  assign w_do_write = (r_funct3[1:0] == 2'b01) || (r_rs1_idx != 5'd0);
  assign w_trap     = (r_funct3[1:0] == 2'b00) || csr_illegal ||
                      (w_do_write && (r_csr[11:10] == 2'b11));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_funct3      <= '0;
      r_csr         <= '0;
      r_rs1_idx     <= '0;
      r_rs1_val     <= '0;
      r_rd_idx      <= '0;
      r_pc          <= '0;
      r_csr_we      <= 1'b0;
      r_csr_wdata   <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_rd_we   <= 1'b0;
      r_rsp_rd_data <= '0;
      r_rsp_trap    <= 1'b0;
      r_rsp_cause   <= '0;
      r_rsp_tval    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_funct3  <= req_funct3;
            r_csr     <= req_csr;
            r_rs1_idx <= req_rs1_idx;
            r_rs1_val <= req_rs1_val;
            r_rd_idx  <= req_rd_idx;
            r_pc      <= req_pc;
            r_state   <= S_READ;
          end
        end
        S_READ: begin
          r_rsp_trap    <= w_trap;
          r_rsp_rd_we   <= !w_trap && (r_rd_idx != 5'd0);
          r_rsp_rd_data <= w_trap ? '0 : csr_rdata;
          r_rsp_cause   <= w_trap ? XLEN'(CAUSE_ILLEGAL) : '0;
          r_rsp_tval    <= w_trap ? {{(XLEN-12){1'b0}}, r_csr} : '0;
          if (w_do_write && !w_trap) begin
            r_csr_we    <= 1'b1;
            r_csr_wdata <= w_new;
            r_state     <= S_WRITE;
          end else begin
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESP;
          end
        end
        S_WRITE: begin
          r_csr_we    <= 1'b0;
          r_csr_wdata <= '0;
          r_rsp_valid <= 1'b1;
          r_state     <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready   = (r_state == S_IDLE);
  assign csr_addr    = r_csr;
  assign csr_we      = r_csr_we;
  assign csr_wdata   = r_csr_wdata;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_rd_we   = r_rsp_rd_we;
  assign rsp_rd_idx  = r_rd_idx;
  assign rsp_rd_data = r_rsp_rd_data;
  assign rsp_trap    = r_rsp_trap;
  assign rsp_cause   = r_rsp_cause;
  assign rsp_tval    = r_rsp_tval;
  assign rsp_pc      = r_pc;

endmodule

// File: tb/tb_csr_exec_unit.sv
// Bench for csr_exec_unit: behavioural CSR file plus directed and random Zicsr ops.
module tb_csr_exec_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_funct3;
  logic [11:0] req_csr;
  logic [4:0]  req_rs1_idx;
  logic [63:0] req_rs1_val;
  logic [4:0]  req_rd_idx;
  logic [63:0] req_pc;
  logic [11:0] csr_addr;
  logic        csr_we;
  logic [63:0] csr_wdata;
  logic [63:0] csr_rdata;
  logic        csr_illegal;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_rd_we;
  logic [4:0]  rsp_rd_idx;
  logic [63:0] rsp_rd_data;
  logic        rsp_trap;
  logic [63:0] rsp_cause;
  logic [63:0] rsp_tval;
  logic [63:0] rsp_pc;

  int n_cmp = 0;
  int n_err = 0;

  logic [63:0] csr_mem [0:4095];

  always #5 clk = ~clk;

  csr_exec_unit #(.XLEN(64), .CAUSE_ILLEGAL(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_funct3(req_funct3),
    .req_csr(req_csr), .req_rs1_idx(req_rs1_idx), .req_rs1_val(req_rs1_val),
    .req_rd_idx(req_rd_idx), .req_pc(req_pc),
    .csr_addr(csr_addr), .csr_we(csr_we), .csr_wdata(csr_wdata),
    .csr_rdata(csr_rdata), .csr_illegal(csr_illegal),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rd_we(rsp_rd_we),
    .rsp_rd_idx(rsp_rd_idx), .rsp_rd_data(rsp_rd_data), .rsp_trap(rsp_trap),
    .rsp_cause(rsp_cause), .rsp_tval(rsp_tval), .rsp_pc(rsp_pc)
  );

  function automatic bit is_unimpl(input logic [11:0] a);
    return (a == 12'h7FF) || (a[11:8] == 4'h5);
  endfunction

  assign csr_rdata   = csr_mem[csr_addr];
  assign csr_illegal = is_unimpl(csr_addr);

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic scramble_req();
    req_funct3  = 3'($urandom);
    req_csr     = 12'($urandom);
    req_rs1_idx = 5'($urandom);
    req_rs1_val = {$urandom, $urandom};
    req_rd_idx  = 5'($urandom);
    req_pc      = {$urandom, $urandom};
  endtask

  task automatic offer(input logic [2:0] f3, input logic [11:0] a, input logic [4:0] r1,
                       input logic [63:0] v, input logic [4:0] rd, input logic [63:0] pc,
                       output bit ok);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_funct3 = f3; req_csr = a; req_rs1_idx = r1;
    req_rs1_val = v; req_rd_idx = rd; req_pc = pc;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    ok = req_ready;
    if (!ok) begin
      chk("accept_timeout", 64'(req_ready), 64'd1);
      req_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      scramble_req();
    end
  endtask

  // Reference: decode the mnemonic, then apply the architectural CSR rules.
  task automatic do_op(input logic [2:0] f3, input logic [11:0] a, input logic [4:0] r1,
                       input logic [63:0] v, input logic [4:0] rd, input logic [63:0] pc,
                       input int stall);
    logic [63:0] old_v, op, nv, exp_data, exp_cause, exp_tval;
    bit is_rw, is_rs, ill_fn, writes, trap, exp_wr, exp_rdwe, ok;
    int lat, wes;
    old_v  = csr_mem[a];
    op     = f3[2] ? {59'd0, r1} : v;
    is_rw  = (f3 == 3'd1) || (f3 == 3'd5);
    is_rs  = (f3 == 3'd2) || (f3 == 3'd6);
    ill_fn = (f3 == 3'd0) || (f3 == 3'd4);
    nv     = is_rw ? op : (is_rs ? (old_v | op) : (old_v & ~op));
    writes = is_rw || (r1 != 5'd0);
    trap   = ill_fn || is_unimpl(a) || (writes && (a >= 12'hC00));
    exp_wr    = writes && !trap;
    exp_rdwe  = !trap && (rd != 5'd0);
    exp_data  = trap ? 64'd0 : old_v;
    exp_cause = trap ? 64'd2 : 64'd0;
    exp_tval  = trap ? {52'd0, a} : 64'd0;

    offer(f3, a, r1, v, rd, pc, ok);
    if (!ok) return;
    lat = 0;
    wes = 0;
    do begin
      @(negedge clk);
      lat++;
      if (csr_we) begin
        wes++;
        chk("we_addr", 64'(csr_addr), 64'(a));
        chk("we_data", csr_wdata, nv);
        csr_mem[csr_addr] = csr_wdata;
      end
    end while (!rsp_valid && lat < 10);
    chk("latency", 64'(lat), exp_wr ? 64'd3 : 64'd2);
    chk("we_count", 64'(wes), 64'(exp_wr));
    if (!rsp_valid) begin
      chk("rsp_timeout", 64'(rsp_valid), 64'd1);
      return;
    end
    chk("rd_data", rsp_rd_data, exp_data);
    chk("rsp_ctl", 64'({rsp_trap, rsp_rd_we, rsp_rd_idx}), 64'({trap, exp_rdwe, rd}));
    chk("cause", rsp_cause, exp_cause);
    chk("tval", rsp_tval, exp_tval);
    chk("pc", rsp_pc, pc);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("hold_data", rsp_rd_data, exp_data);
      chk("hold_ctl", 64'({rsp_valid, req_ready, csr_we, rsp_trap, rsp_rd_we, rsp_rd_idx}),
          64'({1'b1, 1'b0, 1'b0, trap, exp_rdwe, rd}));
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    chk("post_idle", 64'({rsp_valid, req_ready}), 64'd1);
  endtask

  task automatic reset_mid_write();
    bit ok;
    int n;
    csr_mem[12'h340] = 64'h55;
    offer(3'd1, 12'h340, 5'd7, 64'hABC, 5'd1, 64'h4000, ok);
    if (!ok) return;
    n = 0;
    while (!csr_we && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("rst_we_seen", 64'(csr_we), 64'd1);
    rst = 1'b1;
    #1;
    chk("rst_async", 64'({csr_we, rsp_valid, req_ready}), 64'b001);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rst_quiet", 64'({csr_we, rsp_valid, req_ready}), 64'b001);
    end
  endtask

  initial begin
    logic [11:0] addrs [0:8];
    addrs = '{12'h340, 12'h300, 12'h305, 12'hC00, 12'hC01, 12'h7FF, 12'h512, 12'h341, 12'hF14};
    for (int i = 0; i < 4096; i++) csr_mem[i] = {$urandom, $urandom};
    rst = 1'b1;
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    scramble_req();
    #3;
    chk("reset_out", 64'({req_ready, csr_we, rsp_valid, csr_addr}), 64'({1'b1, 1'b0, 1'b0, 12'h000}));
    chk("reset_wdata", csr_wdata, 64'd0);
    chk("reset_rsp", 64'({rsp_trap, rsp_rd_we, rsp_rd_idx}), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    csr_mem[12'h340] = 64'h11;
    do_op(3'd1, 12'h340, 5'd9, 64'hDEAD, 5'd5, 64'h1000, 0);
    csr_mem[12'hC00] = 64'h1234_5678;
    do_op(3'd2, 12'hC00, 5'd0, 64'hFFFF, 5'd6, 64'h1004, 0);
    csr_mem[12'h300] = 64'hFF;
    do_op(3'd7, 12'h300, 5'd5, 64'h0, 5'd7, 64'h1008, 0);
    chk("rrci_result", csr_mem[12'h300], 64'hFA);
    do_op(3'd2, 12'hC01, 5'd3, 64'h1, 5'd8, 64'h100C, 0);
    do_op(3'd1, 12'h7FF, 5'd4, 64'h77, 5'd9, 64'h1010, 1);
    do_op(3'd4, 12'h340, 5'd4, 64'h77, 5'd9, 64'h1014, 0);
    do_op(3'd3, 12'h340, 5'd2, 64'hF0F0, 5'd10, 64'h1018, 4);
    do_op(3'd5, 12'h305, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 5'd0, 64'h101C, 2);
    reset_mid_write();
    do_op(3'd1, 12'h340, 5'd7, 64'hCAFE, 5'd3, 64'h2000, 0);

    for (int k = 0; k < 80; k++) begin
      do_op(3'($urandom),
            addrs[$urandom_range(0, 8)],
            ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
            {$urandom, $urandom},
            ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
            {$urandom, $urandom},
            int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
